// File: rtl/spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// spi_ram_ctrl
// Command-decoding single-port RAM fed by the SPI slave FSM. Each accepted
// 10-bit word carries a 2-bit opcode in din[9:8] and an 8-bit payload in
// din[7:0]:
//   2'b00 WR_ADDR : load write address
//   2'b01 WR_DATA : write payload to mem[wr_addr]
//   2'b10 RD_ADDR : load read address
//   2'b11 RD_DATA : return mem[rd_addr] on dout with a tx_valid pulse
// A data command issued before its address command, or to an address at or
// beyond MEM_DEPTH, raises a one-cycle err pulse. A failed read still pulses
// tx_valid and returns 8'h00, so the serializer always has a byte to shift.
//
// Optional build macro: SPI_RAM_AUTO_INC_EN
//   When defined, each successful WR_DATA / RD_DATA advances its address by
//   one, wrapping from MEM_DEPTH-1 to 0 (burst access after one address).
//
// Ports:
//   clk      in   1   clock, rising edge
//   rst      in   1   synchronous reset, active-high
//   din      in   10  command word {opcode[1:0], payload[7:0]}
//   rx_valid in   1   din valid, one command consumed per asserted cycle
//   dout     out  8   read data, held until next RD_DATA or reset
//   tx_valid out  1   dout valid, one-cycle pulse
//   err      out  1   protocol/range error, one-cycle pulse
// -----------------------------------------------------------------------------
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] din,
    input  logic       rx_valid,
    output logic [7:0] dout,
    output logic       tx_valid,
    output logic       err
);

    // Address registers are at least as wide as the 8-bit payload so the
    // range check sees every payload bit, even for a shallow memory.
    localparam int AW = (ADDR_SIZE > 8) ? ADDR_SIZE : 8;
    localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(MEM_DEPTH);

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    // Which address registers have been loaded since reset.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WA   = 2'b01,
        ST_RA   = 2'b10,
        ST_BOTH = 2'b11
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_wr_addr;
    logic [AW-1:0]   r_rd_addr;
    logic [7:0]      r_mem [0:MEM_DEPTH-1];

    logic            w_wr_vld;
    logic            w_rd_vld;
    logic            w_wr_ok;
    logic            w_rd_ok;
    logic [IW-1:0]   w_wr_idx;
    logic [IW-1:0]   w_rd_idx;

    assign w_wr_vld = (r_state == ST_WA) || (r_state == ST_BOTH);
    assign w_rd_vld = (r_state == ST_RA) || (r_state == ST_BOTH);
    assign w_wr_ok  = w_wr_vld && ({1'b0, r_wr_addr} < DEPTH_W);
    assign w_rd_ok  = w_rd_vld && ({1'b0, r_rd_addr} < DEPTH_W);
    assign w_wr_idx = r_wr_addr[IW-1:0];
    assign w_rd_idx = r_rd_addr[IW-1:0];

`ifdef SPI_RAM_AUTO_INC_EN
    localparam logic [AW-1:0] ADDR_LAST = AW'(MEM_DEPTH - 1);
    logic [AW-1:0] w_wr_next;
    logic [AW-1:0] w_rd_next;
    assign w_wr_next = (r_wr_addr == ADDR_LAST) ? '0 : r_wr_addr + 1'b1;
    assign w_rd_next = (r_rd_addr == ADDR_LAST) ? '0 : r_rd_addr + 1'b1;
`endif

    // Memory write port kept free of reset so it maps onto block RAM.
    // Reset still suppresses a colliding command.
    always_ff @(posedge clk) begin
        if (!rst && rx_valid && (din[9:8] == OP_WR_DATA) && w_wr_ok) begin
            r_mem[w_wr_idx] <= din[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wr_addr <= '0;
            r_rd_addr <= '0;
            dout      <= 8'h00;
            tx_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            err      <= 1'b0;
            if (rx_valid) begin
                case (din[9:8])
                    OP_WR_ADDR: begin
                        r_wr_addr <= AW'(din[7:0]);
                        r_state   <= w_rd_vld ? ST_BOTH : ST_WA;
                    end
                    OP_WR_DATA: begin
                        if (w_wr_ok) begin
`ifdef SPI_RAM_AUTO_INC_EN
                            r_wr_addr <= w_wr_next;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    OP_RD_ADDR: begin
                        r_rd_addr <= AW'(din[7:0]);
                        r_state   <= w_wr_vld ? ST_BOTH : ST_RA;
                    end
                    default: begin // OP_RD_DATA
                        tx_valid <= 1'b1;
                        if (w_rd_ok) begin
                            dout <= r_mem[w_rd_idx];
`ifdef SPI_RAM_AUTO_INC_EN
                            r_rd_addr <= w_rd_next;
`endif
                        end else begin
                            // Failed read still hands the serializer a byte.
                            dout <= 8'h00;
                            err  <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_ram_ctrl
// Drives two instances of spi_ram_ctrl (MEM_DEPTH 256 and 128) with the same
// command stream. A behavioural model per instance predicts dout/tx_valid/err
// each cycle; directed sequences add literal expectations.
// -----------------------------------------------------------------------------
module tb_spi_ram_ctrl;

    localparam bit AUTO =
`ifdef SPI_RAM_AUTO_INC_EN
        1'b1;
`else
        1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] din = '0;
    logic       rx_valid = 1'b0;

    logic [7:0] dut_dout [2];
    logic       dut_tx   [2];
    logic       dut_err  [2];

    int n_cmp = 0;
    int n_bad = 0;
    int n_txn = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    spi_ram_ctrl #(.MEM_DEPTH(256), .ADDR_SIZE(8)) u_dut_big (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dut_dout[0]), .tx_valid(dut_tx[0]), .err(dut_err[0])
    );

    spi_ram_ctrl #(.MEM_DEPTH(128), .ADDR_SIZE(8)) u_dut_small (
        .clk(clk), .rst(rst), .din(din), .rx_valid(rx_valid),
        .dout(dut_dout[1]), .tx_valid(dut_tx[1]), .err(dut_err[1])
    );

    task automatic chk(input string nm, input int idx,
                       input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst%0d] t=%0t: got %02h expected %02h",
                     nm, idx, $time, act, exp);
        end
    endtask

    // Behavioural model and per-cycle compare, one per instance.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_model
            localparam int DEP = (gi == 0) ? 256 : 128;
            logic [7:0] m_mem [256];
            logic [7:0] m_wa, m_ra;
            bit         m_wv, m_rv;
            logic [7:0] e_dout;
            bit         e_tx, e_err;

            always @(posedge clk) begin
                if (rst) begin
                    m_wa <= 8'h00; m_ra <= 8'h00; m_wv <= 1'b0; m_rv <= 1'b0;
                    e_dout <= 8'h00; e_tx <= 1'b0; e_err <= 1'b0;
                end else begin
                    e_tx  <= 1'b0;
                    e_err <= 1'b0;
                    if (rx_valid) begin
                        case (din[9:8])
                            2'd0: begin m_wa <= din[7:0]; m_wv <= 1'b1; end
                            2'd1: begin
                                if (m_wv && int'(m_wa) < DEP) begin
                                    m_mem[m_wa] <= din[7:0];
                                    if (AUTO) m_wa <= 8'((int'(m_wa) + 1) % DEP);
                                end else begin
                                    e_err <= 1'b1;
                                end
                            end
                            2'd2: begin m_ra <= din[7:0]; m_rv <= 1'b1; end
                            default: begin
                                e_tx <= 1'b1;
                                if (m_rv && int'(m_ra) < DEP) begin
                                    e_dout <= m_mem[m_ra];
                                    if (AUTO) m_ra <= 8'((int'(m_ra) + 1) % DEP);
                                end else begin
                                    e_dout <= 8'h00;
                                    e_err  <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end

            always @(negedge clk) begin
                if (chk_en) begin
                    chk("dout",     gi, dut_dout[gi],       e_dout);
                    chk("tx_valid", gi, {7'd0, dut_tx[gi]}, {7'd0, e_tx});
                    chk("err",      gi, {7'd0, dut_err[gi]}, {7'd0, e_err});
                end
            end
        end
    endgenerate

    // Apply one command at a negedge; returns at the next negedge, when the
    // outputs caused by that command are visible.
    task automatic step(input logic [9:0] d, input logic v, input logic r);
        din      = d;
        rx_valid = v;
        rst      = r;
        n_txn++;
        $display("txn %0d: rst=%b rx_valid=%b din=%03h", n_txn, r, v, d);
        @(negedge clk);
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        step(10'h000, 1'b0, 1'b1);
        chk_en = 1'b1;
        // Reset state
        chk("rst_dout", 0, dut_dout[0], 8'h00);
        chk("rst_tx",   0, {7'd0, dut_tx[0]},  8'h00);
        chk("rst_err",  0, {7'd0, dut_err[0]}, 8'h00);

        // Read before any address: err + tx, dout 0
        step(10'h300, 1'b1, 1'b0);
        chk("noaddr_tx",   0, {7'd0, dut_tx[0]},  8'h01);
        chk("noaddr_err",  0, {7'd0, dut_err[0]}, 8'h01);
        chk("noaddr_dout", 0, dut_dout[0], 8'h00);

        // Fill every location with a known pattern
        for (int a = 0; a < 256; a++) begin
            step({2'b00, 8'(a)}, 1'b1, 1'b0);
            step({2'b01, 8'(a) ^ 8'h3C}, 1'b1, 1'b0);
        end

        // Write then read back 0x12
        step(10'h012, 1'b1, 1'b0);
        chk("wa_err", 0, {7'd0, dut_err[0]}, 8'h00);
        step(10'h1A5, 1'b1, 1'b0);
        chk("wd_err", 0, {7'd0, dut_err[0]}, 8'h00);
        chk("wd_tx",  0, {7'd0, dut_tx[0]},  8'h00);
        step(10'h212, 1'b1, 1'b0);
        chk("ra_err", 0, {7'd0, dut_err[0]}, 8'h00);
        step(10'h300, 1'b1, 1'b0);
        chk("rd_tx",   0, {7'd0, dut_tx[0]},  8'h01);
        chk("rd_dout", 0, dut_dout[0], 8'hA5);
        chk("rd_err",  0, {7'd0, dut_err[0]}, 8'h00);
        step(10'h000, 1'b0, 1'b0);
        chk("rd_tx_pulse", 0, {7'd0, dut_tx[0]}, 8'h00);
        chk("dout_hold",   0, dut_dout[0], 8'hA5);

        // Location 0 = 0x00, then WR_DATA right after reset must not write
        step(10'h000, 1'b1, 1'b0);
        step(10'h100, 1'b1, 1'b0);
        step(10'h000, 1'b0, 1'b1);
        step(10'h155, 1'b1, 1'b0);
        chk("wd_noaddr_err", 0, {7'd0, dut_err[0]}, 8'h01);
        step(10'h000, 1'b1, 1'b0);
        step(10'h200, 1'b1, 1'b0);
        step(10'h300, 1'b1, 1'b0);
        chk("nowrite_dout", 0, dut_dout[0], 8'h00);
        chk("nowrite_err",  0, {7'd0, dut_err[0]}, 8'h00);

        // Out-of-range on the 128-deep instance; big instance stores 0x11
        step(10'h0FF, 1'b1, 1'b0);
        step(10'h111, 1'b1, 1'b0);
        chk("oor_wr_err", 1, {7'd0, dut_err[1]}, 8'h01);
        chk("inr_wr_err", 0, {7'd0, dut_err[0]}, 8'h00);
        step(10'h2FF, 1'b1, 1'b0);
        step(10'h300, 1'b1, 1'b0);
        chk("oor_rd_dout", 1, dut_dout[1], 8'h00);
        chk("oor_rd_tx",   1, {7'd0, dut_tx[1]},  8'h01);
        chk("oor_rd_err",  1, {7'd0, dut_err[1]}, 8'h01);
        chk("inr_rd_dout", 0, dut_dout[0], 8'h11);

        // Reset colliding with RD_DATA
        step(10'h212, 1'b1, 1'b0);
        step(10'h300, 1'b1, 1'b0);
        chk("pre_col_dout", 0, dut_dout[0], 8'hA5);
        step(10'h300, 1'b1, 1'b1);
        chk("col_tx",   0, {7'd0, dut_tx[0]}, 8'h00);
        chk("col_dout", 0, dut_dout[0], 8'h00);
        step(10'h300, 1'b1, 1'b0);
        chk("post_col_err", 0, {7'd0, dut_err[0]}, 8'h01);

        if (AUTO) begin
            step(10'h0FF, 1'b1, 1'b0);
            step(10'h111, 1'b1, 1'b0);
            step(10'h122, 1'b1, 1'b0);
            step(10'h2FF, 1'b1, 1'b0);
            step(10'h300, 1'b1, 1'b0);
            chk("burst_rd0", 0, dut_dout[0], 8'h11);
            step(10'h300, 1'b1, 1'b0);
            chk("burst_rd1", 0, dut_dout[0], 8'h22);
            chk("burst_tx1", 0, {7'd0, dut_tx[0]}, 8'h01);
        end

        // Randomized traffic, checked every cycle by the model
        for (int i = 0; i < 3000; i++) begin
            logic [9:0] d;
            logic       v;
            logic       r;
            d = 10'($urandom);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 99) == 0);
            step(d, v, r);
        end

        step(10'h000, 1'b0, 1'b0);
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_ram_ctrl.md
Name: spi_ram_ctrl

Overview:
Command-decoding single-port RAM that sits directly downstream of the SPI slave FSM. It consumes the FSM's 10-bit rx_data/rx_valid words and uses the top two bits as an opcode to set addresses, write data, or fetch read data. Read data is returned on dout/tx_valid to the parallel-to-serial stage, which shifts it out on MISO.

Parameters:
MEM_DEPTH  256  number of 8-bit words stored
ADDR_SIZE  8    address width; MEM_DEPTH must be <= 2**ADDR_SIZE

Ports:
clk       input   1   clock, all logic on rising edge
rst       input   1   synchronous reset, active-high
din       input   10  command word from SPI FSM; [9:8] opcode, [7:0] payload
rx_valid  input   1   din is valid this cycle; one command consumed per asserted cycle
dout      output  8   read data to parallel-to-serial stage
tx_valid  output  1   dout valid; one-cycle pulse
err       output  1   protocol/range error; one-cycle pulse

Behaviour:
- Reset: one clock, synchronous, active-high (rst sampled on rising clk edge).
  - Reset values: dout = 8'h00, tx_valid = 0, err = 0, wr_addr = 0, rd_addr = 0.
  - Reset also clears the flags wr_addr_vld and rd_addr_vld.
  - Memory array is not cleared.
  - rst wins over a simultaneous rx_valid; that command is dropped.
- Decoding happens only when rx_valid = 1 at the rising edge. With rx_valid = 0, all registers hold, and tx_valid/err return to 0.
- Opcode 2'b00, WR_ADDR:
  - wr_addr <= din[7:0]; wr_addr_vld <= 1.
  - No output pulse.
- Opcode 2'b01, WR_DATA:
  - If wr_addr_vld = 1 and wr_addr < MEM_DEPTH: mem[wr_addr] <= din[7:0].
  - Otherwise: no write, and err pulses the next cycle.
- Opcode 2'b10, RD_ADDR:
  - rd_addr <= din[7:0]; rd_addr_vld <= 1.
  - No output pulse.
- Opcode 2'b11, RD_DATA (din[7:0] is don't-care):
  - If rd_addr_vld = 1 and rd_addr < MEM_DEPTH: dout <= mem[rd_addr]; tx_valid = 1 for exactly the next cycle.
  - If rd_addr_vld = 0: dout <= 8'h00, tx_valid pulses, and err pulses in the same cycle.
  - If rd_addr >= MEM_DEPTH: same as rd_addr_vld = 0 (dout <= 8'h00, tx_valid and err pulse).
- Latency: 1 clock from the rx_valid edge to the tx_valid/err pulse.
- dout holds its value until the next RD_DATA or reset.
- Back-to-back commands on consecutive cycles are legal.
  - RD_DATA one cycle after WR_DATA to the same address returns the newly written byte (write-first ordering across cycles).
  - Consecutive RD_DATA commands produce consecutive tx_valid pulses.
- Address registers persist across commands. Repeated WR_DATA without a new WR_ADDR writes the same location (unless the optional feature below is enabled).
- Internal sequencing state (wr_addr_vld, rd_addr_vld): IDLE (neither valid) -> WA (write address set), RA (read address set), or BOTH. Flags only set on the corresponding address command and only clear on rst.

Optional Feature:
Macro: SPI_RAM_AUTO_INC_EN
- Defined:
  - After each successful WR_DATA, wr_addr increments by 1, wrapping from MEM_DEPTH-1 to 0.
  - After each successful RD_DATA, rd_addr increments the same way.
  - Failed (err) operations do not increment.
  - This allows burst writes/reads after a single address command.
- Not defined: addresses change only on WR_ADDR/RD_ADDR.

Test Plan:
- Reset then RD_DATA (din = 10'h300) -> next cycle tx_valid = 1, err = 1, dout = 8'h00.
- WR_ADDR 10'h012, WR_DATA 10'h1A5, RD_ADDR 10'h212, RD_DATA 10'h300 -> tx_valid pulse one cycle after RD_DATA, dout = 8'hA5, err = 0 throughout.
- WR_DATA 10'h155 immediately after reset -> err pulse, no write. Then WR_ADDR 10'h000, RD_ADDR 10'h200, RD_DATA -> dout differs from 8'h55 (verify location 0 preloaded with 8'h00 via a prior write).
- Set MEM_DEPTH = 128: WR_ADDR 10'h0FF, WR_DATA 10'h111 -> err pulse. RD_ADDR 10'h2FF, RD_DATA -> dout = 8'h00, tx_valid = 1, err = 1.
- Assert rst in the same cycle as rx_valid with RD_DATA after a valid read setup -> tx_valid stays 0, dout = 8'h00, and a subsequent RD_DATA flags err.
- With SPI_RAM_AUTO_INC_EN: WR_ADDR 10'h0FF (MEM_DEPTH = 256), WR_DATA 8'h11 then 8'h22 -> mem[255] = 8'h11, mem[0] = 8'h22. RD_ADDR 10'h2FF, two RD_DATA -> dout 8'h11 then 8'h22 on consecutive tx_valid pulses.
